motion_arbiter: RTL and testbench
=================================

Name: motion_arbiter

Overview:
- Shares the drive unit (motion_command/output_speed) between up to 4 motion behaviours (e.g. bump escape, spin, spiral_move, wander).
- Each behaviour raises a request. The arbiter grants exactly one, drives that behaviour's enable, and registers its command/speed to the drive outputs.
- Fixed priority: index 0 is highest. Preemption is gated by a minimum hold time.
- A stop gap is inserted between owners so the drive never sees back-to-back commands from different behaviours.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..4.
- MIN_HOLD, 8, cycles an owner keeps the grant before a higher-priority requester may preempt it.
- GAP_CYCLES, 2, stop cycles inserted between owners; legal range >=1.
- WDOG_CYCLES, 1024, maximum grant length in cycles; used only with WATCHDOG_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request per behaviour; level, held while the behaviour wants the drive.
- req_cmd  in  NUM_REQ*10  packed motion commands; slice k = [10k+9:10k].
- req_speed  in  NUM_REQ*3  packed speeds; slice k = [3k+2:3k].
- grant  out  NUM_REQ  one-hot or zero; drives each behaviour's enable.
- motion_command  out  10  registered command to the drive.
- output_speed  out  3  registered speed to the drive.
- owner_id  out  2  index of the current owner; valid when busy=1.
- busy  out  1  high in GRANT.
- preempt  out  1  one-cycle pulse when an owner is preempted.
- wdog_trip  out  1  sticky watchdog flag; cleared only by rst.

Behaviour:
- Reset (rst sampled high at a posedge): all outputs 0, state IDLE, hold and gap counters 0, mask 0. Reset mid-grant removes the grant and stops the drive on the next edge.
- States: IDLE, GRANT, GAP.
- IDLE:
  - Outputs are stop (cmd 0, speed 0, grant 0).
  - If any unmasked req is high, select the lowest index k. Next cycle: GRANT, grant[k]=1, owner_id=k, busy=1, hold=0.
- GRANT (owner k):
  - Each cycle: motion_command <= req_cmd slice k, speed <= req_speed slice k. One-cycle latency from input to output.
  - hold increments and saturates at its maximum.
  - req[k] low -> GAP.
  - Else, if any req[j] with j<k is high and hold >= MIN_HOLD-1 -> GAP with preempt=1 for one cycle. This makes the owner's minimum tenure MIN_HOLD cycles.
  - Requests with j>k are ignored.
  - Release takes priority over preemption in the same cycle; preempt stays 0.
- GAP:
  - grant=0, busy=0, cmd=0, speed=0 for exactly GAP_CYCLES cycles (gap counter counts 0..GAP_CYCLES-1).
  - Then re-arbitrate: same rule as IDLE, granting directly to GRANT on the next cycle. If no requests, go to IDLE.
- Requests sampled during GAP do not shorten it.
- A behaviour whose req drops and re-rises during GAP competes normally.
- owner_id holds its last value while not busy.
- Widths:
  - hold counter sized for max(MIN_HOLD, WDOG_CYCLES): 11 bits at defaults.
  - gap counter: ceil(log2(GAP_CYCLES+1)) bits, minimum 1.

Optional Feature:
- Macro: MOTION_ARBITER_WATCHDOG_EN.
- Defined:
  - In GRANT, hold reaching WDOG_CYCLES-1 forces GAP next cycle and sets wdog_trip.
  - The owner's mask bit is set, excluding it from arbitration until its req is seen low.
  - Watchdog and release in the same cycle: release wins and no trip is recorded.
- Undefined: no forced release; mask always 0; wdog_trip tied 0.

Decomposition:
- Package motion_pkg:
  - constants CMD_W=10, SPD_W=3, ID_W=2;
  - state encodings ST_IDLE, ST_GRANT, ST_GAP;
  - STOP_CMD=10'd0, STOP_SPD=3'd0.
- One sub-module: prio_pick. Combinational lowest-index-first selector over masked req, returning valid plus index. It is reused for the initial grant, for re-arbitration after GAP, and for the higher-priority check (req masked to indices below k).

Test Plan:
- Reset: rst high 2 cycles with req=4'b1111 -> grant=0, cmd=0, speed=0, busy=0 throughout, and for 1 cycle after release. Then grant=4'b0001.
- Single request: req=4'b0100, cmd2=10'h155, speed2=3'd5 -> next cycle grant=4'b0100, owner_id=2, cmd=10'h155, speed=5. Drop req2 -> 2 stop cycles, then IDLE.
- Preemption timing: req2 owner, assert req0 at hold=3 -> no switch until 8 cycles of tenure, then preempt pulse, 2 stop cycles, grant=4'b0001.
- Lower priority ignored: owner 0 with req3 high for 50 cycles -> grant stays 4'b0001 and preempt never fires. Release req0 -> GAP 2 cycles, grant=4'b1000.
- Simultaneous release and higher-priority request at hold>=7 -> GAP entered with preempt=0. Afterwards grant goes to the higher-priority requester.
- With MOTION_ARBITER_WATCHDOG_EN, WDOG_CYCLES=16, req1 held high:
  - grant drops after 16 cycles, wdog_trip=1, req1 not regranted while held;
  - req1 low 1 cycle then high -> regranted after GAP.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared constants and state encoding for the motion arbiter.
package motion_pkg;

  localparam int CMD_W = 10;
  localparam int SPD_W = 3;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [CMD_W-1:0] STOP_CMD = 10'd0;
  localparam logic [SPD_W-1:0] STOP_SPD = 3'd0;

endpackage

// File: rtl/motion_arbiter_prio_pick.sv
// Lowest-index-first selector: reports whether any request is set and which index wins.
module prio_pick
  import motion_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/motion_arbiter.sv
// Fixed-priority drive arbiter with minimum hold, stop gap between owners and
// optional grant watchdog (enabled by defining MOTION_ARBITER_WATCHDOG_EN).
//
// state    | meaning
// ST_IDLE  | no owner, drive stopped, arbitrating every cycle
// ST_GRANT | one owner drives motion_command/output_speed
// ST_GAP   | drive stopped for GAP_CYCLES between owners
module motion_arbiter
  import motion_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MIN_HOLD    = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  input  logic [NUM_REQ*SPD_W-1:0] req_speed,
  output logic [NUM_REQ-1:0]       grant,
  output logic [CMD_W-1:0]         motion_command,
  output logic [SPD_W-1:0]         output_speed,
  output logic [ID_W-1:0]          owner_id,
  output logic                     busy,
  output logic                     preempt,
  output logic                     wdog_trip
);

  localparam int HOLD_TOP = (MIN_HOLD > WDOG_CYCLES) ? MIN_HOLD : WDOG_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_TOP + 1);
  localparam int GAP_W    = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  state_t              state, state_next;
  logic [HOLD_W-1:0]   hold;
  logic [GAP_W-1:0]    gap_cnt;
  logic [NUM_REQ-1:0]  mask;
  logic [NUM_REQ-1:0]  avail;
  logic [NUM_REQ-1:0]  below;
  logic [NUM_REQ-1:0]  pick_req;
  logic                pick_valid;
  logic [ID_W-1:0]     pick_idx;
  logic [ID_W-1:0]     sel;
  logic                go_grant;
  logic                do_preempt;
`ifdef MOTION_ARBITER_WATCHDOG_EN
  logic                do_trip;
`endif

  assign avail = req & ~mask;

  always_comb begin
    below = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      below[i] = (ID_W'(i) < owner_id);
    end
  end

  // One picker serves both arbitration and the higher-priority check while granted.
  assign pick_req = (state == ST_GRANT) ? (avail & below) : avail;

  prio_pick #(.N(NUM_REQ)) u_pick (
    .req   (pick_req),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    go_grant   = 1'b0;
    do_preempt = 1'b0;
`ifdef MOTION_ARBITER_WATCHDOG_EN
    do_trip    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next = ST_GRANT;
          go_grant   = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!req[owner_id]) begin
          state_next = ST_GAP;
        end
`ifdef MOTION_ARBITER_WATCHDOG_EN
        else if (hold == HOLD_W'(WDOG_CYCLES - 1)) begin
          state_next = ST_GAP;
          do_trip    = 1'b1;
        end
`endif
        else if (pick_valid && hold >= HOLD_W'(MIN_HOLD - 1)) begin
          state_next = ST_GAP;
          do_preempt = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          if (pick_valid) begin
            state_next = ST_GRANT;
            go_grant   = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == ST_GRANT);
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = busy && (owner_id == ID_W'(i));
    end
  end

  assign sel = go_grant ? pick_idx : owner_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_id       <= '0;
      hold           <= '0;
      gap_cnt        <= '0;
      preempt        <= 1'b0;
      motion_command <= STOP_CMD;
      output_speed   <= STOP_SPD;
    end else begin
      preempt <= do_preempt;
      if (go_grant) begin
        owner_id <= pick_idx;
      end
      if (state == ST_GRANT && state_next == ST_GRANT) begin
        hold <= (hold == {HOLD_W{1'b1}}) ? hold : hold + 1'b1;
      end else begin
        hold <= '0;
      end
      if (state == ST_GAP && state_next == ST_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
      if (state_next == ST_GRANT) begin
        motion_command <= req_cmd[int'(sel) * CMD_W +: CMD_W];
        output_speed   <= req_speed[int'(sel) * SPD_W +: SPD_W];
      end else begin
        motion_command <= STOP_CMD;
        output_speed   <= STOP_SPD;
      end
    end
  end

`ifdef MOTION_ARBITER_WATCHDOG_EN
  // A tripped owner stays masked until it lets go of its request.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask      <= '0;
      wdog_trip <= 1'b0;
    end else begin
      mask <= (mask & req) | (do_trip ? grant : '0);
      if (do_trip) begin
        wdog_trip <= 1'b1;
      end
    end
  end
`else
  assign mask      = '0;
  assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_motion_arbiter.sv
// Self-checking bench for motion_arbiter: directed scenarios plus random traffic vs a behavioural model.
module tb_motion_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int GC = 2;
`ifdef MOTION_ARBITER_WATCHDOG_EN
  localparam int WD = 16;
  localparam bit WDOG_ON = 1'b1;
`else
  localparam int WD = 1024;
  localparam bit WDOG_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_GRANT = 1, M_GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [39:0] req_cmd;
  logic [11:0] req_speed;
  logic [3:0]  grant;
  logic [9:0]  motion_command;
  logic [2:0]  output_speed;
  logic [1:0]  owner_id;
  logic        busy;
  logic        preempt;
  logic        wdog_trip;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motion_arbiter #(
    .NUM_REQ(N), .MIN_HOLD(MH), .GAP_CYCLES(GC), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_speed(req_speed),
    .grant(grant), .motion_command(motion_command), .output_speed(output_speed),
    .owner_id(owner_id), .busy(busy), .preempt(preempt), .wdog_trip(wdog_trip)
  );

  // Behavioural model: who owns the drive, for how long, and how much gap is left.
  int         m_mode = M_IDLE, m_owner = 0, m_ten = 0, m_gap = 0;
  logic [3:0] m_mask = '0, m_grant = '0;
  logic       m_trip = 1'b0, m_pre = 1'b0, m_busy = 1'b0;
  logic [9:0] m_cmd = '0;
  logic [2:0] m_spd = '0;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int k;
    logic [3:0] hi;
    if (rst) begin
      m_mode = M_IDLE; m_owner = 0; m_ten = 0; m_gap = 0;
      m_mask = '0; m_trip = 1'b0; m_pre = 1'b0;
    end else begin
      m_pre  = 1'b0;
      k      = -1;
      m_mask = m_mask & req;
      case (m_mode)
        M_IDLE: k = lowest(req & ~m_mask);
        M_GRANT: begin
          hi = req & ~m_mask & 4'((1 << m_owner) - 1);
          if (!req[m_owner]) begin
            m_mode = M_GAP;
          end else if (WDOG_ON && m_ten >= WD - 1) begin
            m_mode = M_GAP; m_trip = 1'b1; m_mask[m_owner] = 1'b1;
          end else if (hi != 0 && m_ten >= MH - 1) begin
            m_mode = M_GAP; m_pre = 1'b1;
          end else begin
            m_ten++;
          end
          m_gap = 0;
        end
        default: begin
          m_gap++;
          if (m_gap == GC) begin
            k = lowest(req & ~m_mask);
            if (k < 0) m_mode = M_IDLE;
          end
        end
      endcase
      if (k >= 0) begin
        m_mode = M_GRANT; m_owner = k; m_ten = 0;
      end
    end
    m_busy  = (m_mode == M_GRANT);
    m_grant = m_busy ? 4'(1 << m_owner) : 4'b0;
    m_cmd   = m_busy ? req_cmd[m_owner*10 +: 10] : 10'd0;
    m_spd   = m_busy ? req_speed[m_owner*3 +: 3] : 3'd0;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 4'b1111;
    req_cmd = 40'h12_3456_789A; req_speed = 12'hABC;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0 || motion_command !== 10'd0 || output_speed !== 3'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d grant=%b cmd=%h spd=%0d busy=%b want all 0", i, grant, motion_command, output_speed, busy);
      end
    end
    rst = 1'b0;
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || motion_command !== 10'd0) begin
      errors++;
      $display("FAIL reset_release grant=%b busy=%b cmd=%h want 0", grant, busy, motion_command);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || motion_command !== 10'h09A || output_speed !== 3'd4) begin
      errors++;
      $display("FAIL reset_first_grant grant=%b cmd=%h spd=%0d want 0001/09a/4", grant, motion_command, output_speed);
    end
  endtask

  task automatic test_single;
    req = 4'b0000;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b grant=%b want 0", busy, grant);
    end
    req = 4'b0100;
    req_cmd[29:20] = 10'h155; req_speed[8:6] = 3'd5;
    tick();
    checks++;
    if (grant !== 4'b0100 || owner_id !== 2'd2 || motion_command !== 10'h155 || output_speed !== 3'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant grant=%b id=%0d cmd=%h spd=%0d busy=%b want 0100/2/155/5/1", grant, owner_id, motion_command, output_speed, busy);
    end
    req_cmd[29:20] = 10'h2AA; req_speed[8:6] = 3'd2;
    tick();
    checks++;
    if (motion_command !== 10'h2AA || output_speed !== 3'd2) begin
      errors++;
      $display("FAIL single_follow cmd=%h spd=%0d want 2aa/2", motion_command, output_speed);
    end
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0 || motion_command !== 10'd0 || output_speed !== 3'd0 || busy !== 1'b0 || owner_id !== 2'd2) begin
        errors++;
        $display("FAIL single_stop cyc%0d grant=%b cmd=%h spd=%0d busy=%b id=%0d want stop, id 2", i, grant, motion_command, output_speed, busy, owner_id);
      end
    end
    tick();
  endtask

  task automatic test_preempt;
    req = 4'b0100;
    tick();
    repeat (3) tick();
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0100 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL preempt_hold cyc%0d grant=%b preempt=%b want 0100/0", i, grant, preempt);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0 || preempt !== 1'b1 || motion_command !== 10'd0) begin
      errors++;
      $display("FAIL preempt_pulse grant=%b preempt=%b cmd=%h want 0/1/0", grant, preempt, motion_command);
    end
    tick();
    checks++;
    if (grant !== 4'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL preempt_gap2 grant=%b preempt=%b want 0/0", grant, preempt);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || owner_id !== 2'd0) begin
      errors++;
      $display("FAIL preempt_new_owner grant=%b id=%0d want 0001/0", grant, owner_id);
    end
  endtask

  task automatic test_low_ignored;
    req = 4'b1001;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL low_ignored cyc%0d grant=%b preempt=%b want 0001/0", i, grant, preempt);
      end
    end
    req = 4'b1000;
    repeat (2) begin
      tick();
      checks++;
      if (grant !== 4'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL low_gap grant=%b busy=%b want 0/0", grant, busy);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b1000 || owner_id !== 2'd3) begin
      errors++;
      $display("FAIL low_regrant grant=%b id=%0d want 1000/3", grant, owner_id);
    end
  endtask

  task automatic test_release_vs_preempt;
    repeat (8) tick();
    req = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL release_wins grant=%b busy=%b preempt=%b want 0/0/0", grant, busy, preempt);
    end
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010 || owner_id !== 2'd1) begin
      errors++;
      $display("FAIL release_next_owner grant=%b id=%0d want 0010/1", grant, owner_id);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
      req_cmd   = 40'({$urandom(), $urandom()});
      req_speed = 12'($urandom());
      tick();
      checks++;
      if (grant !== m_grant || busy !== m_busy || motion_command !== m_cmd || output_speed !== m_spd ||
          preempt !== m_pre || wdog_trip !== m_trip || owner_id !== 2'(m_owner)) begin
        errors++;
        $display("FAIL random cyc%0d got g=%b b=%b c=%h s=%0d p=%b w=%b id=%0d want g=%b b=%b c=%h s=%0d p=%b w=%b id=%0d",
                 c, grant, busy, motion_command, output_speed, preempt, wdog_trip, owner_id,
                 m_grant, m_busy, m_cmd, m_spd, m_pre, m_trip, m_owner);
      end
    end
    rst = 1'b0;
  endtask

`ifdef MOTION_ARBITER_WATCHDOG_EN
  task automatic test_watchdog;
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    req = 4'b0010;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0010 || wdog_trip !== 1'b0) begin
        errors++;
        $display("FAIL wdog_hold cyc%0d grant=%b trip=%b want 0010/0", i, grant, wdog_trip);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0 || wdog_trip !== 1'b1) begin
      errors++;
      $display("FAIL wdog_trip grant=%b trip=%b want 0/1", grant, wdog_trip);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0) begin
        errors++;
        $display("FAIL wdog_masked cyc%0d grant=%b want 0", i, grant);
      end
    end
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0010 || wdog_trip !== 1'b1) begin
      errors++;
      $display("FAIL wdog_regrant grant=%b trip=%b want 0010/1", grant, wdog_trip);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_low_ignored();
    test_release_vs_preempt();
    test_random();
`ifdef MOTION_ARBITER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
